if_id_stage: RTL

Pipeline register between the fetch path (program counter plus instruction memory) and the decode stage. It accepts one fetched word per cycle with its word-indexed PC over a valid/ready handshake, and buffers up to two entries so a decode-side stall never drops a fetch. It presents the oldest entry to decode with the MIPS-style fields already split out. It also supports a synchronous flush for branch/jump redirects, and keeps a wrap-around counter of instructions delivered.

---
 rtl/if_id_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// Fetch-to-decode pipeline register. Accepts one {pc, instr} pair per cycle
// over a valid/ready handshake and holds up to two entries, so a decode stall
// never drops an instruction that fetch has already issued. The oldest entry
// is presented to decode with the MIPS fields already split out.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   flush          synchronous discard of all entries and any same-cycle enqueue
//   in_valid       fetch side presents in_pc / in_instr
//   in_ready       stage can take an entry this cycle (registered state only)
//   in_pc          word-indexed PC of the fetched instruction
//   in_instr       fetched instruction word
//   out_valid      head entry valid for decode
//   out_ready      decode consumes the head this cycle
//   out_pc         PC of the head entry (0 when empty)
//   out_pc_plus1   out_pc + 1, wrapping
//   out_instr      head instruction word (NOP_INSTR when empty)
//   opcode, rs, rt, rd, shamt, funct, imm, imm_sext, jaddr
//                  decode fields of out_instr
//   is_rtype / is_itype / is_jtype
//                  instruction class, one-hot while valid, all 0 when empty
//   delivered_cnt  number of completed output handshakes, wraps at 2^32
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [PC_W-1:0] out_pc_plus1,
  output logic [31:0]     out_instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [31:0]     imm_sext,
  output logic [25:0]     jaddr,
  output logic            is_rtype,
  output logic            is_itype,
  output logic            is_jtype,
  output logic [31:0]     delivered_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [1:0]      count_p1;
  logic [PC_W-1:0] head_pc_p1;
  logic [31:0]     head_instr_p1;
  logic [PC_W-1:0] tail_pc_p1;
  logic [31:0]     tail_instr_p1;
  logic [31:0]     dlv_cnt_p1;

  logic enq;
  logic deq;

  // Handshake is decided purely from registered occupancy, so out_ready has
  // no combinational path to in_ready.
  assign in_ready  = (count_p1 != FULL);
  assign out_valid = (count_p1 != EMPTY);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // ---- stage p1: two-entry buffer (head is always the oldest entry) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_p1      <= EMPTY;
      head_pc_p1    <= '0;
      head_instr_p1 <= NOP_INSTR;
      tail_pc_p1    <= '0;
      tail_instr_p1 <= NOP_INSTR;
    end else if (flush) begin
      count_p1      <= EMPTY;
      head_pc_p1    <= '0;
      head_instr_p1 <= NOP_INSTR;
      tail_pc_p1    <= '0;
      tail_instr_p1 <= NOP_INSTR;
    end else begin
      case (count_p1)
        EMPTY: begin
          if (enq) begin
            head_pc_p1    <= in_pc;
            head_instr_p1 <= in_instr;
            count_p1      <= ONE;
          end
        end
        ONE: begin
          if (enq && deq) begin
            // Head leaves while the new word arrives: new word becomes head.
            head_pc_p1    <= in_pc;
            head_instr_p1 <= in_instr;
          end else if (enq) begin
            tail_pc_p1    <= in_pc;
            tail_instr_p1 <= in_instr;
            count_p1      <= FULL;
          end else if (deq) begin
            head_pc_p1    <= '0;
            head_instr_p1 <= NOP_INSTR;
            count_p1      <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a dequeue can happen.
          if (deq) begin
            head_pc_p1    <= tail_pc_p1;
            head_instr_p1 <= tail_instr_p1;
            tail_pc_p1    <= '0;
            tail_instr_p1 <= NOP_INSTR;
            count_p1      <= ONE;
          end
        end
        default: begin
          count_p1 <= EMPTY;
        end
      endcase
    end
  end

  // A dequeue in the same cycle as a flush was a real handshake, so it is
  // counted regardless of flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dlv_cnt_p1 <= '0;
    end else if (deq) begin
      dlv_cnt_p1 <= dlv_cnt_p1 + 32'd1;
    end
  end

  assign delivered_cnt = dlv_cnt_p1;

  // ---- decode view of the head entry (combinational) ----
  // Outputs are masked on occupancy so an empty stage always looks like a NOP
  // at PC 0, independent of what the head register happens to hold.
  assign out_pc       = out_valid ? head_pc_p1    : '0;
  assign out_instr    = out_valid ? head_instr_p1 : NOP_INSTR;
  assign out_pc_plus1 = pc_inc(out_pc);

  assign opcode   = out_instr[31:26];
  assign rs       = out_instr[25:21];
  assign rt       = out_instr[20:16];
  assign rd       = out_instr[15:11];
  assign shamt    = out_instr[10:6];
  assign funct    = out_instr[5:0];
  assign imm      = out_instr[15:0];
  assign imm_sext = sext16(out_instr[15:0]);
  assign jaddr    = out_instr[25:0];

  assign is_rtype = out_valid && (opcode == OP_RTYPE);
  assign is_jtype = out_valid && ((opcode == OP_J) || (opcode == OP_JAL));
  assign is_itype = out_valid && (opcode != OP_RTYPE) && (opcode != OP_J) &&
                    (opcode != OP_JAL);

endmodule
